// File: rtl/fully_associative_cache_fill.sv
// Miss-handling / line-fill controller for the 256-entry fully associative cache.
// Optional feature: define FA_FILL_INVALID_FIRST_EN to prefer the lowest invalid entry as victim.
module fully_associative_cache_fill #(
  parameter  int NUM_LINES = 256,
  parameter  int TAG_W     = 12,
  parameter  int ADDR_W    = 16,
  localparam int IDX_W     = $clog2(NUM_LINES),
  localparam int LINE_W    = TAG_W + 129
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 miss_valid,
  input  logic [ADDR_W-1:0]    miss_addr,
  output logic                 miss_ready,
  input  logic [NUM_LINES-1:0] valid_vec,
  output logic                 mem_req_valid,
  output logic [ADDR_W-1:0]    mem_req_addr,
  input  logic                 mem_req_ready,
  input  logic                 mem_rsp_valid,
  input  logic [31:0]          mem_rsp_data,
  output logic                 line_we,
  output logic [IDX_W-1:0]     line_idx,
  output logic [LINE_W-1:0]    line_data,
  output logic                 fill_done,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, REQ, RECV, WRITE} state_t;

  state_t            state, state_nxt;
  logic [TAG_W-1:0]  tag_q;
  logic [IDX_W-1:0]  rr_ptr, victim_q, victim_sel;
  logic              use_rr_q, use_rr_sel;
  logic [1:0]        cnt_q;
  logic [127:0]      words_q;
  logic              accept;

  logic [3:0] unused_offset;
  assign unused_offset = miss_addr[3:0];

`ifdef FA_FILL_INVALID_FIRST_EN
  // Descending scan so the lowest invalid index wins.
  always_comb begin
    victim_sel = rr_ptr;
    use_rr_sel = 1'b1;
    for (int i = NUM_LINES-1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        victim_sel = IDX_W'(i);
        use_rr_sel = 1'b0;
      end
    end
  end
`else
  logic unused_valid;
  assign unused_valid = ^valid_vec;
  assign victim_sel   = rr_ptr;
  assign use_rr_sel   = 1'b1;
`endif

  assign accept = miss_valid && miss_ready;

  // Words shift in from the bottom: after four, w0 sits at [127:96] and w3 at [31:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tag_q    <= '0;
      rr_ptr   <= '0;
      victim_q <= '0;
      use_rr_q <= 1'b0;
      cnt_q    <= '0;
      words_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          tag_q    <= miss_addr[ADDR_W-1 -: TAG_W];
          victim_q <= victim_sel;
          use_rr_q <= use_rr_sel;
        end
        REQ:  if (mem_req_ready) cnt_q <= '0;
        RECV: if (mem_rsp_valid) begin
          words_q <= {words_q[95:0], mem_rsp_data};
          cnt_q   <= cnt_q + 2'd1;
        end
        WRITE: if (use_rr_q) rr_ptr <= rr_ptr + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt     = state;
    miss_ready    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    line_we       = 1'b0;
    line_idx      = '0;
    line_data     = '0;
    fill_done     = 1'b0;
    busy          = 1'b0;
    if (!rst) begin
      mem_req_addr = ADDR_W'({tag_q, 4'b0000});
      line_idx     = victim_q;
      busy         = (state != IDLE);
      case (state)
        IDLE: begin
          miss_ready = 1'b1;
          if (miss_valid) state_nxt = REQ;
        end
        REQ: begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) state_nxt = RECV;
        end
        RECV: if (mem_rsp_valid && cnt_q == 2'd3) state_nxt = WRITE;
        WRITE: begin
          line_we   = 1'b1;
          fill_done = 1'b1;
          line_data = {1'b1, tag_q, words_q};
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/fully_associative_cache_fill.md
# fully_associative_cache_fill

Miss-handling and line-fill controller for the 256-entry fully associative cache. Accepts a miss address from the lookup side, issues one line-aligned read request to memory, collects four 32-bit response words, and writes a complete 141-bit line (valid, tag, data) into a victim entry chosen by the replacement logic. It is the write side of the cache array whose lookup path consumes these lines.

## Interface
- NUM_LINES, 256, number of cache entries; victim index width is $clog2(NUM_LINES)
- TAG_W, 12, tag width, taken from addr[15:4]
- ADDR_W, 16, physical address width
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- miss_valid  input  1  miss request present
- miss_addr  input  ADDR_W  address that missed
- miss_ready  output  1  controller can accept a miss (IDLE only)
- valid_vec  input  NUM_LINES  current valid bit of every entry (bit 140 of each line)
- mem_req_valid  output  1  memory read request
- mem_req_addr  output  ADDR_W  line-aligned address, {tag, 4'b0000}
- mem_req_ready  input  1  memory accepts request
- mem_rsp_valid  input  1  response word present; no backpressure
- mem_rsp_data  input  32  response word; word offsets 0,1,2,3 in order
- line_we  output  1  one-cycle line write strobe into the array
- line_idx  output  $clog2(NUM_LINES)  victim entry index
- line_data  output  TAG_W+129  {1'b1, tag, w0, w1, w2, w3}; w0 at [127:96], w3 at [31:0]
- fill_done  output  1  one-cycle pulse, same cycle as line_we
- busy  output  1  high in any state other than IDLE

## Operation
- FSM: IDLE -> REQ -> RECV -> WRITE -> IDLE.
- IDLE: miss_ready=1. On miss_valid && miss_ready, latch tag=miss_addr[15:4], select and latch victim, go to REQ. miss_addr[3:0] is ignored.
- REQ: mem_req_valid=1, mem_req_addr={tag,4'b0}, both held stable until mem_req_ready; on the handshake cycle, go to RECV with word counter 0.
- RECV: each mem_rsp_valid cycle stores mem_rsp_data at slot 3-count (bits 32*(3-count)+:32), counter increments; the cycle storing the 4th word (count=3) moves to WRITE. Idle cycles (mem_rsp_valid=0) are allowed between words.
- WRITE: line_we=1, fill_done=1, line_idx=victim, line_data=assembled line with bit 140 set; go to IDLE.
- mem_rsp_valid outside RECV is ignored, with no state change.
- The word placement ensures a lookup at offset addr[3:2] reads slot ~addr[3:2].
- Victim selection: 8-bit round-robin pointer, reset 0; victim = pointer; pointer increments (wraps 255->0) in WRITE only when the round-robin victim was used.
- No duplicate-miss filtering: two misses to the same line produce two fills.

## Timing
- Reset values: miss_ready=0 during rst, mem_req_valid=0, mem_req_addr=0, line_we=0, line_idx=0, line_data=0, fill_done=0, busy=0; FSM=IDLE, pointer=0, word buffer=0, counter=0.
- First cycle after rst deasserts: miss_ready=1.
- Miss accepted at cycle T: mem_req_valid=1 at T+1. With zero-wait memory (ready at T+1, words at T+2..T+5): line_we/fill_done at T+6, miss_ready=1 at T+7.
- miss_ready is 0 from T+1 until the cycle after WRITE; a miss held on miss_valid is accepted only then.
- Reset mid-fill (any state): next cycle IDLE, all outputs at reset values, partial line discarded, no line_we issued.
- line_data and line_idx are qualified only by line_we; the array ignores them otherwise.

## Configuration
- FA_FILL_INVALID_FIRST_EN defined: at acceptance, if any valid_vec bit is 0, victim = lowest-index invalid entry and the round-robin pointer is not advanced; if all are valid, the round-robin victim is used and the pointer advances in WRITE.
- Undefined: round-robin only; valid_vec is ignored, and the port remains present.

## Test plan
- Reset, then miss_addr=16'hABC4, zero-wait memory, words 11111111/22222222/33333333/44444444 -> mem_req_addr=16'hABC0; line_we at T+6, line_idx=0, line_data={1'b1,12'hABC,32'h11111111,32'h22222222,32'h33333333,32'h44444444}.
- mem_req_ready held low 5 cycles, with gaps of 3 cycles between response words -> mem_req_valid/addr stable throughout; line is identical to the zero-wait case; miss_ready=0 until after fill_done.
- 257 back-to-back fills (macro off, or all valid_vec=1) -> line_idx runs 0..255, then 0 again.
- Macro on, valid_vec all 1 except bits 7 and 200 -> victim 7; pointer unchanged; a second fill with bit 7 set -> victim 200.
- rst pulsed after 2 response words -> no line_we; outputs at reset values; a following fill lands at index 0 with correct data.
- mem_rsp_valid pulses while in IDLE/REQ -> ignored; counter stays 0; the subsequent fill is correct.
